// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: FSM state encoding,
// display constants and the clock-divider ratio helper.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_e;

  // Display value width: 6 decimal digits need up to 999999 < 2**20.
  localparam int DATA_W = 20;

  // Decimal point fixed on digit 2 (XXXX.XX).
  localparam logic [5:0] DP_MASK = 6'b000100;

  // Number of clock cycles per event at the given rate; never below 1.
  function automatic int tick_div(input int clk_freq, input int rate_hz);
    int div;
    div = (rate_hz > 0) ? (clk_freq / rate_hz) : 1;
    return (div > 0) ? div : 1;
  endfunction

endpackage

// File: rtl/stopwatch_tick_gen.sv
// Free-running divider that pulses tick_o for one cycle every DIV cycles of
// run_i. The count is frozen while run_i is low and forced to 0 by clr_i.
module stopwatch_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise advance and wrap while running.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick_o = run_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Up/down centisecond stopwatch feeding a 6-digit dynamic display (XXXX.XX).
// Optional feature macro: PAUSE_BLINK_EN -- blinks the display enable while
// paused. Without it en is held at 1 and no blink counter is built.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int TICK_HZ   = 100,
  parameter int PRESET    = 6000,
  parameter int UP_LIMIT  = 999999,
  parameter int OVT_LIMIT = 99999,
  parameter int BLINK_HZ  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_start_stop,
  input  logic              key_clear,
  input  logic              mode,
  output logic [DATA_W-1:0] data,
  output logic [5:0]        point,
  output logic              en,
  output logic              sign,
  output state_e            state_o
);

  localparam int TICK_DIV = tick_div(CLK_FREQ, TICK_HZ);
  localparam logic [DATA_W-1:0] PRESET_V = DATA_W'(PRESET);
  localparam logic [DATA_W-1:0] UP_V     = DATA_W'(UP_LIMIT);
  localparam logic [DATA_W-1:0] OVT_V    = DATA_W'(OVT_LIMIT);

  // Down mode starts from PRESET, so it has to fit under the up limit.
  if (PRESET > UP_LIMIT || TICK_HZ < 1 || BLINK_HZ < 1) begin : g_param_check
    $error("stopwatch_ctrl: invalid parameter set");
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sign_q, sign_d;
  logic              mode_q, mode_d;  // direction latched when leaving IDLE
  logic              lim_q, lim_d;    // limit reached: resume is blocked
  logic              en_q, en_d;
  logic [5:0]        point_q;
  logic [DATA_W-1:0] data_inc;
  logic              tick;

  assign data_inc = data_q + DATA_W'(1);

  // Count-rate divider: runs only in RUN, held at 0 in IDLE and on clear.
  stopwatch_tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .run_i  (state_q == RUN),
    .clr_i  (key_clear || (state_q == IDLE)),
    .tick_o (tick)
  );

  // FSM next state and count update; clear beats every other event.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sign_d  = sign_q;
    mode_d  = mode_q;
    lim_d   = lim_q;
    if (key_clear) begin
      state_d = IDLE;
      data_d  = mode ? PRESET_V : '0;
      sign_d  = 1'b0;
      lim_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          data_d = mode ? PRESET_V : '0;
          sign_d = 1'b0;
          if (key_start_stop) begin
            state_d = RUN;
            mode_d  = mode;
          end
        end
        RUN: begin
          if (key_start_stop) state_d = PAUSE;
          if (tick) begin
            if (!mode_q) begin
              if (data_q < UP_V) data_d = data_inc;
              if (data_inc >= UP_V) begin
                lim_d   = 1'b1;
                state_d = PAUSE;
              end
            end else if (!sign_q && data_q != '0) begin
              data_d = data_q - DATA_W'(1);
            end else begin
              // Counting away from zero in overtime; zero itself stays positive.
              data_d = data_inc;
              sign_d = 1'b1;
              if (data_inc >= OVT_V) begin
                lim_d   = 1'b1;
                state_d = PAUSE;
              end
            end
          end
        end
        PAUSE: begin
          if (key_start_stop && !lim_q) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

`ifdef PAUSE_BLINK_EN
  localparam int BLINK_DIV = tick_div(CLK_FREQ, 2 * BLINK_HZ);
  logic blink_tick;

  // Blink divider restarts on every entry into PAUSE.
  stopwatch_tick_gen #(.DIV(BLINK_DIV)) u_blink (
    .clk    (clk),
    .rst    (rst),
    .run_i  (state_q == PAUSE),
    .clr_i  (state_q != PAUSE),
    .tick_o (blink_tick)
  );

  // Enable toggles only while staying in PAUSE; any entry or exit forces it on.
  always_comb begin
    en_d = 1'b1;
    if (state_q == PAUSE && state_d == PAUSE) begin
      en_d = blink_tick ? ~en_q : en_q;
    end
  end
`else
  // Display always enabled.
  always_comb begin
    en_d = 1'b1;
  end
`endif

  // Registered state and display outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      sign_q  <= 1'b0;
      mode_q  <= 1'b0;
      lim_q   <= 1'b0;
      en_q    <= 1'b1;
      point_q <= DP_MASK;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sign_q  <= sign_d;
      mode_q  <= mode_d;
      lim_q   <= lim_d;
      en_q    <= en_d;
      point_q <= DP_MASK;
    end
  end

  assign data    = data_q;
  assign sign    = sign_q;
  assign en      = en_q;
  assign point   = point_q;
  assign state_o = state_q;

endmodule
